// File: rtl/ln_psum_router.sv
// ln_psum_router: per-column elastic links chaining PE row r+1 opsums into row r ipsums, else GIN/GON passthrough.
// Optional LN_STALL_CNT_EN adds a saturating producer-stall counter on stall_cnt.
module ln_psum_router #(
  parameter int NUMS_PE_ROW = 6,
  parameter int NUMS_PE_COL = 8,
  parameter int DATA_BITS   = 32,
  parameter int LINK_DEPTH  = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       set_LN,
  input  logic [NUMS_PE_ROW-2:0]                     LN_config_in,
  input  logic                                       flush,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_opsum_valid,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_opsum_ready,
  input  logic [DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_opsum_data,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_ipsum_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         pe_ipsum_ready,
  output logic [DATA_BITS*NUMS_PE_ROW*NUMS_PE_COL-1:0] pe_ipsum_data,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gin_ipsum_valid,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gin_ipsum_ready,
  input  logic [DATA_BITS-1:0]                       gin_ipsum_data,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gon_opsum_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]         gon_opsum_ready,
  output logic [NUMS_PE_ROW-2:0]                     ln_cfg,
  output logic                                       link_busy,
  output logic                                       cfg_reject,
  output logic [31:0]                                stall_cnt
);
  localparam int C  = NUMS_PE_COL;
  localparam int N  = NUMS_PE_ROW * NUMS_PE_COL;
  localparam int L  = (NUMS_PE_ROW - 1) * NUMS_PE_COL;
  localparam int DB = DATA_BITS;
  localparam int AW = $clog2(LINK_DEPTH);

  logic [NUMS_PE_ROW-2:0] ln_cfg_q, ln_cfg_d;
  logic                   link_busy_q, link_busy_d;
  logic                   cfg_reject_q, cfg_reject_d;
  logic [L-1:0]           act, empty, full, ne_d;
  logic [DB*L-1:0]        head;
  logic                   unused_ok;

  // Link l joins PE l (row r ipsum) with PE l+C (row r+1 opsum).
  for (genvar l = 0; l < L; l++) begin : g_link
    logic [AW:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DB-1:0]  mem_q [LINK_DEPTH];
    logic [DB-1:0]  mem_d [LINK_DEPTH];
    logic           push, pop;
    assign act[l]   = ln_cfg_q[l / C];
    assign empty[l] = wptr_q == rptr_q;
    assign full[l]  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    assign push     = act[l] && pe_opsum_valid[l + C] && !full[l] && !flush;
    assign pop      = act[l] && pe_ipsum_ready[l] && !empty[l] && !flush;
    assign head[l*DB +: DB] = mem_q[rptr_q[AW-1:0]];
    assign ne_d[l]  = wptr_d != rptr_d;
    always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wptr_q[AW-1:0]] = pe_opsum_data[(l+C)*DB +: DB];
      wptr_d = flush ? '0 : wptr_q + {{AW{1'b0}}, push};
      rptr_d = flush ? '0 : rptr_q + {{AW{1'b0}}, pop};
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr_q <= '0;
        rptr_q <= '0;
        mem_q  <= '{default: '0};
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        mem_q  <= mem_d;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pe
    if (i < L) begin : g_ip_link
      assign pe_ipsum_valid[i]          = act[i] ? !empty[i] : gin_ipsum_valid[i];
      assign pe_ipsum_data[i*DB +: DB]  = act[i] ? head[i*DB +: DB] : gin_ipsum_data;
      assign gin_ipsum_ready[i]         = !act[i] && pe_ipsum_ready[i];
    end else begin : g_ip_gin
      assign pe_ipsum_valid[i]          = gin_ipsum_valid[i];
      assign pe_ipsum_data[i*DB +: DB]  = gin_ipsum_data;
      assign gin_ipsum_ready[i]         = pe_ipsum_ready[i];
    end
    if (i >= C) begin : g_op_link
      assign gon_opsum_valid[i] = !act[i-C] && pe_opsum_valid[i];
      assign pe_opsum_ready[i]  = act[i-C] ? !full[i-C] : gon_opsum_ready[i];
    end else begin : g_op_gon
      assign gon_opsum_valid[i] = pe_opsum_valid[i];
      assign pe_opsum_ready[i]  = gon_opsum_ready[i];
    end
  end

  // Row 0 opsum data travels on GON outside this block.
  assign unused_ok = ^pe_opsum_data[C*DB-1:0];

  // Reconfiguration is only safe once every link has drained.
  always_comb begin
    ln_cfg_d     = (set_LN && !link_busy_q) ? LN_config_in : ln_cfg_q;
    cfg_reject_d = set_LN && link_busy_q;
    link_busy_d  = |ne_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ln_cfg_q     <= '0;
      link_busy_q  <= 1'b0;
      cfg_reject_q <= 1'b0;
    end else begin
      ln_cfg_q     <= ln_cfg_d;
      link_busy_q  <= link_busy_d;
      cfg_reject_q <= cfg_reject_d;
    end
  end

  assign ln_cfg     = ln_cfg_q;
  assign link_busy  = link_busy_q;
  assign cfg_reject = cfg_reject_q;

`ifdef LN_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  always_comb
    stall_cnt_d = flush ? '0 :
                  (|(act & pe_opsum_valid[N-1:C] & full) && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 :
                  stall_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ln_psum_router.sv
// tb_ln_psum_router: directed and randomized checks of ln_psum_router against a queue-based link model.
module tb_ln_psum_router;
  localparam int R = 6, C = 8, DB = 32, D = 2, N = R * C, L = (R - 1) * C;

  logic              clk = 0, rst = 0, set_LN = 0, flush = 0;
  logic [R-2:0]      LN_config_in = '0, ln_cfg;
  logic [N-1:0]      pe_opsum_valid = '0, pe_opsum_ready, pe_ipsum_valid, pe_ipsum_ready = '0;
  logic [N-1:0]      gin_ipsum_valid = '0, gin_ipsum_ready, gon_opsum_valid, gon_opsum_ready = '0;
  logic [DB*N-1:0]   pe_opsum_data = '0, pe_ipsum_data;
  logic [DB-1:0]     gin_ipsum_data = '0;
  logic              link_busy, cfg_reject;
  logic [31:0]       stall_cnt;

  int n_cmp = 0, n_err = 0;

  logic [DB-1:0]     q [L][$];
  logic [R-2:0]      m_cfg = '0;
  logic              m_rej = 0;
  logic [31:0]       m_stall = 0;
  logic [N-1:0]      e_ipv, e_ginr, e_gonv, e_opr;
  logic [DB*N-1:0]   e_ipd, e_msk;
  logic              e_busy;

  ln_psum_router #(.NUMS_PE_ROW(R), .NUMS_PE_COL(C), .DATA_BITS(DB), .LINK_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .set_LN(set_LN), .LN_config_in(LN_config_in), .flush(flush),
    .pe_opsum_valid(pe_opsum_valid), .pe_opsum_ready(pe_opsum_ready), .pe_opsum_data(pe_opsum_data),
    .pe_ipsum_valid(pe_ipsum_valid), .pe_ipsum_ready(pe_ipsum_ready), .pe_ipsum_data(pe_ipsum_data),
    .gin_ipsum_valid(gin_ipsum_valid), .gin_ipsum_ready(gin_ipsum_ready), .gin_ipsum_data(gin_ipsum_data),
    .gon_opsum_valid(gon_opsum_valid), .gon_opsum_ready(gon_opsum_ready),
    .ln_cfg(ln_cfg), .link_busy(link_busy), .cfg_reject(cfg_reject), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int l = 0; l < L; l++) q[l].delete();
    m_cfg = '0; m_rej = 0; m_stall = 0;
  endtask

  // Expected combinational outputs for the current inputs and link contents.
  task automatic model_eval();
    e_ipv = gin_ipsum_valid; e_ipd = {N{gin_ipsum_data}}; e_msk = '1;
    e_ginr = pe_ipsum_ready; e_gonv = pe_opsum_valid; e_opr = gon_opsum_ready; e_busy = 0;
    for (int l = 0; l < L; l++) begin
      if (q[l].size() != 0) e_busy = 1;
      if (m_cfg[l / C]) begin
        e_ipv[l] = q[l].size() != 0;
        if (q[l].size() != 0) e_ipd[l*DB +: DB] = q[l][0];
        else e_msk[l*DB +: DB] = '0;
        e_ginr[l] = 0;
        e_gonv[l+C] = 0;
        e_opr[l+C] = q[l].size() < D;
      end
    end
  endtask

  task automatic model_commit();
    logic busy = 0;
    for (int l = 0; l < L; l++) if (q[l].size() != 0) busy = 1;
    if (flush) begin
      for (int l = 0; l < L; l++) q[l].delete();
      m_stall = 0;
    end else begin
`ifdef LN_STALL_CNT_EN
      logic hit = 0;
      for (int l = 0; l < L; l++)
        if (m_cfg[l / C] && pe_opsum_valid[l+C] && q[l].size() == D) hit = 1;
      if (hit && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
      for (int l = 0; l < L; l++) begin
        if (m_cfg[l / C]) begin
          logic pu, po;
          pu = pe_opsum_valid[l+C] && q[l].size() < D;
          po = pe_ipsum_ready[l] && q[l].size() != 0;
          if (po) void'(q[l].pop_front());
          if (pu) q[l].push_back(pe_opsum_data[(l+C)*DB +: DB]);
        end
      end
    end
    m_rej = set_LN && busy;
    if (set_LN && !busy) m_cfg = LN_config_in;
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_LN = 0; flush = 0; LN_config_in = '0;
    pe_opsum_valid = '0; pe_ipsum_ready = '0; gin_ipsum_valid = '0; gon_opsum_ready = '0;
    pe_opsum_data = '0; gin_ipsum_data = '0;
  endtask

  task automatic test_reset();
    idle();
    gin_ipsum_valid = '1; gin_ipsum_data = 32'hA5;
    for (int i = 0; i < N; i++) begin
      pe_opsum_valid[i] = 1'($urandom_range(0, 1));
      gon_opsum_ready[i] = 1'($urandom_range(0, 1));
      pe_ipsum_ready[i] = 1'($urandom_range(0, 1));
    end
    #2;
    n_cmp++; if (ln_cfg !== '0) begin n_err++; $display("FAIL reset_ln_cfg got=%h exp=0", ln_cfg); end
    n_cmp++; if (link_busy !== 1'b0) begin n_err++; $display("FAIL reset_link_busy got=%b exp=0", link_busy); end
    n_cmp++; if (cfg_reject !== 1'b0) begin n_err++; $display("FAIL reset_cfg_reject got=%b exp=0", cfg_reject); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    n_cmp++; if (pe_ipsum_valid !== {N{1'b1}}) begin n_err++; $display("FAIL reset_ipsum_valid got=%h exp=all ones", pe_ipsum_valid); end
    n_cmp++; if (pe_ipsum_data !== {N{32'hA5}}) begin n_err++; $display("FAIL reset_ipsum_data got=%h exp=all A5", pe_ipsum_data); end
    n_cmp++; if (gon_opsum_valid !== pe_opsum_valid) begin n_err++; $display("FAIL reset_gon_valid got=%h exp=%h", gon_opsum_valid, pe_opsum_valid); end
    n_cmp++; if (pe_opsum_ready !== gon_opsum_ready) begin n_err++; $display("FAIL reset_opsum_ready got=%h exp=%h", pe_opsum_ready, gon_opsum_ready); end
    n_cmp++; if (gin_ipsum_ready !== pe_ipsum_ready) begin n_err++; $display("FAIL reset_gin_ready got=%h exp=%h", gin_ipsum_ready, pe_ipsum_ready); end
    @(negedge clk);
    rst = 1;
    idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_chain();
    set_LN = 1; LN_config_in = 5'b00001;
    step();
    set_LN = 0;
    #1;
    n_cmp++; if (ln_cfg !== 5'b00001) begin n_err++; $display("FAIL chain_cfg got=%b exp=00001", ln_cfg); end
    pe_opsum_valid[11] = 1; pe_opsum_data[11*DB +: DB] = 32'h1234;
    gin_ipsum_valid[3] = 1; gon_opsum_ready[11] = 1;
    #1;
    n_cmp++; if (pe_opsum_ready[11] !== 1'b1) begin n_err++; $display("FAIL chain_push_ready got=%b exp=1", pe_opsum_ready[11]); end
    n_cmp++; if (gon_opsum_valid[11] !== 1'b0) begin n_err++; $display("FAIL chain_gon_valid got=%b exp=0", gon_opsum_valid[11]); end
    n_cmp++; if (pe_ipsum_valid[3] !== 1'b0) begin n_err++; $display("FAIL chain_empty_valid got=%b exp=0", pe_ipsum_valid[3]); end
    step();
    pe_opsum_valid[11] = 0; pe_ipsum_ready[3] = 1;
    #1;
    n_cmp++; if (pe_ipsum_valid[3] !== 1'b1) begin n_err++; $display("FAIL chain_latency_valid got=%b exp=1", pe_ipsum_valid[3]); end
    n_cmp++; if (pe_ipsum_data[3*DB +: DB] !== 32'h1234) begin n_err++; $display("FAIL chain_data got=%h exp=1234", pe_ipsum_data[3*DB +: DB]); end
    n_cmp++; if (gin_ipsum_ready[3] !== 1'b0) begin n_err++; $display("FAIL chain_gin_ready got=%b exp=0", gin_ipsum_ready[3]); end
    n_cmp++; if (link_busy !== 1'b1) begin n_err++; $display("FAIL chain_busy got=%b exp=1", link_busy); end
    step();
    idle();
    #1;
    n_cmp++; if (link_busy !== 1'b0) begin n_err++; $display("FAIL chain_busy_after_pop got=%b exp=0", link_busy); end
    n_cmp++; if (pe_ipsum_valid[3] !== 1'b0) begin n_err++; $display("FAIL chain_valid_after_pop got=%b exp=0", pe_ipsum_valid[3]); end
  endtask

  task automatic test_stall();
    int k = 0, got = 0;
    logic [31:0] exp_st;
    for (int j = 0; j < 5; j++) begin
      pe_opsum_valid[13] = 1; pe_opsum_data[13*DB +: DB] = 32'(k + 1);
      #1;
      n_cmp++; if (pe_opsum_ready[13] !== (j < 2)) begin n_err++; $display("FAIL stall_ready cyc=%0d got=%b exp=%b", j, pe_opsum_ready[13], j < 2); end
`ifdef LN_STALL_CNT_EN
      exp_st = j > 2 ? 32'(j - 2) : 0;
`else
      exp_st = 0;
`endif
      n_cmp++; if (stall_cnt !== exp_st) begin n_err++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", j, stall_cnt, exp_st); end
      if (j < 2) k++;
      step();
    end
    pe_ipsum_ready[5] = 1;
    for (int t = 0; t < 10 && got < 3; t++) begin
      pe_opsum_valid[13] = k < 3; pe_opsum_data[13*DB +: DB] = 32'(k + 1);
      #1;
      if (pe_ipsum_valid[5]) begin
        n_cmp++; if (pe_ipsum_data[5*DB +: DB] !== 32'(got + 1)) begin n_err++; $display("FAIL stall_drain_order idx=%0d got=%0d exp=%0d", got, pe_ipsum_data[5*DB +: DB], got + 1); end
        got++;
      end
      if (pe_opsum_valid[13] && pe_opsum_ready[13]) k++;
      step();
    end
    n_cmp++; if (got !== 3) begin n_err++; $display("FAIL stall_drain_count got=%0d exp=3", got); end
    idle();
  endtask

  task automatic test_cfg_reject();
    pe_opsum_valid[8] = 1; pe_opsum_data[8*DB +: DB] = 32'hBEEF;
    step();
    pe_opsum_valid[8] = 0; set_LN = 1; LN_config_in = '0;
    #1;
    n_cmp++; if (link_busy !== 1'b1) begin n_err++; $display("FAIL rej_busy got=%b exp=1", link_busy); end
    step();
    set_LN = 0;
    #1;
    n_cmp++; if (cfg_reject !== 1'b1) begin n_err++; $display("FAIL rej_pulse got=%b exp=1", cfg_reject); end
    n_cmp++; if (ln_cfg !== 5'b00001) begin n_err++; $display("FAIL rej_cfg_kept got=%b exp=00001", ln_cfg); end
    pe_ipsum_ready[0] = 1;
    #1;
    n_cmp++; if (pe_ipsum_data[0 +: DB] !== 32'hBEEF) begin n_err++; $display("FAIL rej_data got=%h exp=BEEF", pe_ipsum_data[0 +: DB]); end
    step();
    pe_ipsum_ready[0] = 0;
    #1;
    n_cmp++; if (cfg_reject !== 1'b0) begin n_err++; $display("FAIL rej_pulse_end got=%b exp=0", cfg_reject); end
    n_cmp++; if (link_busy !== 1'b0) begin n_err++; $display("FAIL rej_drained got=%b exp=0", link_busy); end
    set_LN = 1; LN_config_in = '0;
    step();
    set_LN = 0;
    #1;
    n_cmp++; if (ln_cfg !== 5'b00000) begin n_err++; $display("FAIL rej_accept got=%b exp=00000", ln_cfg); end
    n_cmp++; if (cfg_reject !== 1'b0) begin n_err++; $display("FAIL rej_accept_pulse got=%b exp=0", cfg_reject); end
  endtask

  task automatic test_flush();
    set_LN = 1; LN_config_in = 5'b00001;
    step();
    set_LN = 0;
    for (int j = 0; j < 2; j++) begin
      pe_opsum_valid[10] = 1; pe_opsum_data[10*DB +: DB] = 32'(100 + j);
      step();
    end
    flush = 1; pe_opsum_valid[10] = 1; pe_opsum_valid[12] = 1; pe_opsum_data[12*DB +: DB] = 32'h77;
    #1;
    n_cmp++; if (pe_opsum_ready[10] !== 1'b0) begin n_err++; $display("FAIL flush_full_ready got=%b exp=0", pe_opsum_ready[10]); end
    n_cmp++; if (link_busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_before got=%b exp=1", link_busy); end
    step();
    idle();
    #1;
    n_cmp++; if (link_busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_after got=%b exp=0", link_busy); end
    n_cmp++; if (pe_ipsum_valid[2] !== 1'b0 || pe_ipsum_valid[4] !== 1'b0) begin n_err++; $display("FAIL flush_empty got=%b%b exp=00", pe_ipsum_valid[2], pe_ipsum_valid[4]); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL flush_stall_clear got=%0d exp=0", stall_cnt); end
    n_cmp++; if (ln_cfg !== 5'b00001) begin n_err++; $display("FAIL flush_cfg_kept got=%b exp=00001", ln_cfg); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_LN = $urandom_range(0, 7) == 0;
      flush = $urandom_range(0, 39) == 0;
      for (int r = 0; r < R - 1; r++) LN_config_in[r] = $urandom_range(0, 3) != 0;
      gin_ipsum_data = $urandom;
      for (int i = 0; i < N; i++) begin
        pe_opsum_valid[i] = 1'($urandom_range(0, 1));
        pe_ipsum_ready[i] = 1'($urandom_range(0, 1));
        gin_ipsum_valid[i] = 1'($urandom_range(0, 1));
        gon_opsum_ready[i] = 1'($urandom_range(0, 1));
        pe_opsum_data[i*DB +: DB] = $urandom;
      end
      #1;
      model_eval();
      n_cmp++; if (pe_ipsum_valid !== e_ipv) begin n_err++; $display("FAIL rnd_ipsum_valid cyc=%0d got=%h exp=%h", cyc, pe_ipsum_valid, e_ipv); end
      n_cmp++; if ((pe_ipsum_data & e_msk) !== (e_ipd & e_msk)) begin n_err++; $display("FAIL rnd_ipsum_data cyc=%0d got=%h exp=%h", cyc, pe_ipsum_data & e_msk, e_ipd & e_msk); end
      n_cmp++; if (gin_ipsum_ready !== e_ginr) begin n_err++; $display("FAIL rnd_gin_ready cyc=%0d got=%h exp=%h", cyc, gin_ipsum_ready, e_ginr); end
      n_cmp++; if (gon_opsum_valid !== e_gonv) begin n_err++; $display("FAIL rnd_gon_valid cyc=%0d got=%h exp=%h", cyc, gon_opsum_valid, e_gonv); end
      n_cmp++; if (pe_opsum_ready !== e_opr) begin n_err++; $display("FAIL rnd_opsum_ready cyc=%0d got=%h exp=%h", cyc, pe_opsum_ready, e_opr); end
      n_cmp++; if (ln_cfg !== m_cfg) begin n_err++; $display("FAIL rnd_ln_cfg cyc=%0d got=%b exp=%b", cyc, ln_cfg, m_cfg); end
      n_cmp++; if (link_busy !== e_busy) begin n_err++; $display("FAIL rnd_link_busy cyc=%0d got=%b exp=%b", cyc, link_busy, e_busy); end
      n_cmp++; if (cfg_reject !== m_rej) begin n_err++; $display("FAIL rnd_cfg_reject cyc=%0d got=%b exp=%b", cyc, cfg_reject, m_rej); end
      n_cmp++; if (stall_cnt !== m_stall) begin n_err++; $display("FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stall); end
      step();
    end
    idle();
  endtask

  task automatic test_async_reset();
    flush = 1;
    step();
    flush = 0; set_LN = 1; LN_config_in = '1;
    step();
    set_LN = 0;
    for (int j = 0; j < 2; j++) begin
      for (int i = C; i < N; i++) begin
        pe_opsum_valid[i] = 1; pe_opsum_data[i*DB +: DB] = $urandom;
      end
      step();
    end
    for (int i = 0; i < N; i++) begin
      gin_ipsum_valid[i] = 1'($urandom_range(0, 1));
      gon_opsum_ready[i] = 1'($urandom_range(0, 1));
    end
    #1;
    n_cmp++; if (link_busy !== 1'b1) begin n_err++; $display("FAIL arst_busy_before got=%b exp=1", link_busy); end
    #2;
    rst = 0;
    #1;
    model_reset();
    n_cmp++; if (link_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=0", link_busy); end
    n_cmp++; if (ln_cfg !== '0) begin n_err++; $display("FAIL arst_cfg got=%b exp=0", ln_cfg); end
    n_cmp++; if (pe_ipsum_valid !== gin_ipsum_valid) begin n_err++; $display("FAIL arst_ipsum_valid got=%h exp=%h", pe_ipsum_valid, gin_ipsum_valid); end
    n_cmp++; if (gon_opsum_valid !== pe_opsum_valid) begin n_err++; $display("FAIL arst_gon_valid got=%h exp=%h", gon_opsum_valid, pe_opsum_valid); end
    n_cmp++; if (pe_opsum_ready !== gon_opsum_ready) begin n_err++; $display("FAIL arst_opsum_ready got=%h exp=%h", pe_opsum_ready, gon_opsum_ready); end
    @(negedge clk);
    rst = 1;
    idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_chain();
    test_stall();
    test_cfg_reject();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
